// File: rtl/sched_pkg.sv
// Shared definitions for the tile scheduler.
//   - sched_state_e : scheduler FSM state encoding (IDLE = 0 ... DONE = 4)
//   - ROWS_DEFAULT / COLS_DEFAULT : default compute array geometry
package sched_pkg;

  localparam int ROWS_DEFAULT = 4;
  localparam int COLS_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_e;

endpackage

// File: rtl/tile_index_counter.sv
// Three-level nested wrapping counter for (m, n, k) tile indices.
// k is the fastest index, then n, then m. Each index wraps to 0 at its
// count-1 and carries into the next slower index.
//   clk, rst          : clock, asynchronous active-high reset
//   clear             : synchronous reset of all indices to 0 (job accept)
//   advance           : step to the next (m, n, k) tuple
//   m_cnt/n_cnt/k_cnt : tile counts of the current job
//   m_idx/n_idx/k_idx : current indices
//   last              : current tuple is the final one of the job
module tile_index_counter #(
  parameter int TILE_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  input  logic [TILE_W-1:0] m_cnt,
  input  logic [TILE_W-1:0] n_cnt,
  input  logic [TILE_W-1:0] k_cnt,
  output logic [TILE_W-1:0] m_idx,
  output logic [TILE_W-1:0] n_idx,
  output logic [TILE_W-1:0] k_idx,
  output logic              last
);

  logic m_wrap, n_wrap, k_wrap;

  assign m_wrap = (m_idx == m_cnt - TILE_W'(1));
  assign n_wrap = (n_idx == n_cnt - TILE_W'(1));
  assign k_wrap = (k_idx == k_cnt - TILE_W'(1));
  assign last   = m_wrap && n_wrap && k_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idx <= '0;
      n_idx <= '0;
      k_idx <= '0;
    end else if (clear) begin
      m_idx <= '0;
      n_idx <= '0;
      k_idx <= '0;
    end else if (advance) begin
      if (k_wrap) begin
        k_idx <= '0;
        if (n_wrap) begin
          n_idx <= '0;
          m_idx <= m_wrap ? '0 : m_idx + TILE_W'(1);
        end else begin
          n_idx <= n_idx + TILE_W'(1);
        end
      end else begin
        k_idx <= k_idx + TILE_W'(1);
      end
    end
  end

endmodule

// File: rtl/tile_scheduler.sv
// Tile scheduler: accepts a (M, N, K) tile job and walks the array FSM
// controller through every tile run, k fastest, with accumulator clear on
// the first k tile and result store on the last k tile.
//   clk, rst                    : clock, asynchronous active-high reset
//   job_valid / job_ready       : job handshake (ready only in IDLE)
//   job_m/n/k_tiles             : tile counts, sampled on accept
//   abort                       : synchronous cancel of the current job
//   arr_start                   : one-cycle start pulse to the array
//   arr_clear / arr_store       : per-run accumulator clear / result store
//   arr_done                    : run-complete pulse from the array
//   tile_m / tile_n / tile_k    : indices of the current run
//   busy, job_done, job_aborted : status and completion pulses
//   busy_cycles                 : saturating count of non-IDLE cycles
module tile_scheduler
  import sched_pkg::*;
#(
  parameter int TILE_W = 4,
  parameter int ROWS   = ROWS_DEFAULT,
  parameter int COLS   = COLS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [TILE_W-1:0] job_m_tiles,
  input  logic [TILE_W-1:0] job_n_tiles,
  input  logic [TILE_W-1:0] job_k_tiles,
  input  logic              abort,
  output logic              arr_start,
  output logic              arr_clear,
  output logic              arr_store,
  input  logic              arr_done,
  output logic [TILE_W-1:0] tile_m,
  output logic [TILE_W-1:0] tile_n,
  output logic [TILE_W-1:0] tile_k,
  output logic              busy,
  output logic              job_done,
  output logic              job_aborted,
  output logic [31:0]       busy_cycles
);

  // Geometry is carried for the array side only; reject nonsense values.
  if (ROWS < 1 || COLS < 1) begin : g_bad_geom
    $error("tile_scheduler: ROWS and COLS must be positive");
  end

  sched_state_e      state, state_nxt;
  logic [TILE_W-1:0] m_tiles, n_tiles, k_tiles;
  logic [TILE_W-1:0] k_after;
  logic              abort_pend;
  logic              accept, zero_job, last, advance, stop_req;

  assign accept   = job_valid && (state == ST_IDLE);
  assign zero_job = (job_m_tiles == '0) || (job_n_tiles == '0) || (job_k_tiles == '0);
  // In WAIT an abort seen this cycle counts as well as an earlier pending one.
  assign stop_req = abort || abort_pend;
  assign advance  = (state == ST_NEXT) && !abort;
  // k index the counter will hold after this NEXT, for the next run's flags.
  assign k_after  = (tile_k == k_tiles - TILE_W'(1)) ? '0 : tile_k + TILE_W'(1);

  tile_index_counter #(
    .TILE_W (TILE_W)
  ) u_idx (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .advance (advance),
    .m_cnt   (m_tiles),
    .n_cnt   (n_tiles),
    .k_cnt   (k_tiles),
    .m_idx   (tile_m),
    .n_idx   (tile_n),
    .k_idx   (tile_k),
    .last    (last)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (accept) state_nxt = zero_job ? ST_DONE : ST_ISSUE;
      ST_ISSUE: state_nxt = abort ? ST_IDLE : ST_WAIT;
      ST_WAIT:  if (arr_done) state_nxt = stop_req ? ST_IDLE : ST_NEXT;
      ST_NEXT:  state_nxt = abort ? ST_IDLE : (last ? ST_DONE : ST_ISSUE);
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    job_ready   = (state == ST_IDLE);
    busy        = (state != ST_IDLE);
    arr_start   = (state == ST_ISSUE) && !abort;
    job_done    = (state == ST_DONE);
    job_aborted = (((state == ST_ISSUE) || (state == ST_NEXT)) && abort) ||
                  ((state == ST_WAIT) && arr_done && stop_req);
  end

  // Job registers: latched counts, per-run flags, pending abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tiles    <= '0;
      n_tiles    <= '0;
      k_tiles    <= '0;
      arr_clear  <= 1'b0;
      arr_store  <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      if (accept) begin
        m_tiles   <= job_m_tiles;
        n_tiles   <= job_n_tiles;
        k_tiles   <= job_k_tiles;
        arr_clear <= !zero_job;
        arr_store <= !zero_job && (job_k_tiles == TILE_W'(1));
      end else if ((state == ST_NEXT) && (state_nxt == ST_ISSUE)) begin
        arr_clear <= (k_after == '0);
        arr_store <= (k_after == k_tiles - TILE_W'(1));
      end else if ((state_nxt == ST_IDLE) || (state_nxt == ST_DONE)) begin
        arr_clear <= 1'b0;
        arr_store <= 1'b0;
      end

      if (state != ST_WAIT)  abort_pend <= 1'b0;
      else if (abort)        abort_pend <= 1'b1;
    end
  end

  // Saturating busy-cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              busy_cycles <= '0;
    else if (busy && (busy_cycles != '1)) busy_cycles <= busy_cycles + 32'd1;
  end

endmodule

// File: tb/tb_tile_scheduler.sv
module tb_tile_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid;
  logic        job_ready;
  logic [3:0]  job_m_tiles, job_n_tiles, job_k_tiles;
  logic        abort;
  logic        arr_start, arr_clear, arr_store;
  logic        arr_done;
  logic [3:0]  tile_m, tile_n, tile_k;
  logic        busy, job_done, job_aborted;
  logic [31:0] busy_cycles;

  int n_cmp = 0;
  int n_err = 0;

  tile_scheduler #(.TILE_W(4), .ROWS(4), .COLS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .job_valid   (job_valid),
    .job_ready   (job_ready),
    .job_m_tiles (job_m_tiles),
    .job_n_tiles (job_n_tiles),
    .job_k_tiles (job_k_tiles),
    .abort       (abort),
    .arr_start   (arr_start),
    .arr_clear   (arr_clear),
    .arr_store   (arr_store),
    .arr_done    (arr_done),
    .tile_m      (tile_m),
    .tile_n      (tile_n),
    .tile_k      (tile_k),
    .busy        (busy),
    .job_done    (job_done),
    .job_aborted (job_aborted),
    .busy_cycles (busy_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        v;
    logic [3:0]  m, n, k;
    logic        ab, dn;
    logic        st, cl, so, bz, jd, ja, rd;
    logic [31:0] bc;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(input logic v, input logic [3:0] m, input logic [3:0] n,
                              input logic [3:0] k, input logic ab, input logic dn,
                              input logic st, input logic cl, input logic so, input logic bz,
                              input logic jd, input logic ja, input logic rd,
                              input logic [31:0] bc);
    vec_t r;
    r.v = v; r.m = m; r.n = n; r.k = k; r.ab = ab; r.dn = dn;
    r.st = st; r.cl = cl; r.so = so; r.bz = bz; r.jd = jd; r.ja = ja; r.rd = rd;
    r.bc = bc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // From the negedge of an ISSUE cycle: one idle WAIT, one WAIT with arr_done,
  // ending at the negedge of the following NEXT cycle.
  task automatic finish_tile();
    @(negedge clk);
    @(negedge clk); arr_done = 1'b1;
    @(negedge clk); arr_done = 1'b0;
  endtask

  task automatic issue_job(input logic [3:0] m, input logic [3:0] n, input logic [3:0] k);
    @(negedge clk);
    job_valid = 1'b1; job_m_tiles = m; job_n_tiles = n; job_k_tiles = k;
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  initial begin
    bit found;
    int cnt;

    rst = 1'b1; job_valid = 1'b0; abort = 1'b0; arr_done = 1'b0;
    job_m_tiles = '0; job_n_tiles = '0; job_k_tiles = '0;

    // Row layout: v m n k abort done | start clear store busy jdone jabort ready busy_cycles
    vecs[0]  = mk(1'b1,4'd1,4'd1,4'd1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'd0);
    vecs[1]  = mk(1'b0,4'd0,4'd0,4'd0,1'b0,1'b0, 1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'd0);
    vecs[2]  = mk(1'b0,4'd0,4'd0,4'd0,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'd1);
    vecs[3]  = mk(1'b0,4'd0,4'd0,4'd0,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'd2);
    vecs[4]  = mk(1'b0,4'd0,4'd0,4'd0,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'd3);
    vecs[5]  = mk(1'b0,4'd0,4'd0,4'd0,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'd4);
    vecs[6]  = mk(1'b0,4'd0,4'd0,4'd0,1'b0,1'b1, 1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'd5);
    vecs[7]  = mk(1'b0,4'd0,4'd0,4'd0,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'd6);
    vecs[8]  = mk(1'b0,4'd0,4'd0,4'd0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,32'd7);
    vecs[9]  = mk(1'b0,4'd0,4'd0,4'd0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'd8);
    vecs[10] = mk(1'b0,4'd0,4'd0,4'd0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'd8);
    vecs[11] = mk(1'b0,4'd0,4'd0,4'd0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'd8);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(job_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags", {29'd0, arr_start, arr_clear, arr_store}, 32'd0);
    chk("rst_pulses", {30'd0, job_done, job_aborted}, 32'd0);
    chk("rst_idx", {20'd0, tile_m, tile_n, tile_k}, 32'd0);
    chk("rst_bcyc", busy_cycles, 32'd0);
    rst = 1'b0;

    // 1x1x1 job, arr_done 5 cycles after start, then ignored inputs in DONE/IDLE
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      job_valid = vecs[i].v; job_m_tiles = vecs[i].m; job_n_tiles = vecs[i].n;
      job_k_tiles = vecs[i].k; abort = vecs[i].ab; arr_done = vecs[i].dn;
      #1;
      chk($sformatf("v%0d_start", i), 32'(arr_start), 32'(vecs[i].st));
      chk($sformatf("v%0d_clear", i), 32'(arr_clear), 32'(vecs[i].cl));
      chk($sformatf("v%0d_store", i), 32'(arr_store), 32'(vecs[i].so));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].bz));
      chk($sformatf("v%0d_jdone", i), 32'(job_done), 32'(vecs[i].jd));
      chk($sformatf("v%0d_jabort", i), 32'(job_aborted), 32'(vecs[i].ja));
      chk($sformatf("v%0d_ready", i), 32'(job_ready), 32'(vecs[i].rd));
      chk($sformatf("v%0d_bcyc", i), busy_cycles, vecs[i].bc);
    end
    job_valid = 1'b0; abort = 1'b0; arr_done = 1'b0;

    // M=2 N=1 K=3: six runs in (m,k) order, clear on k=0, store on k=2
    issue_job(4'd2, 4'd1, 4'd3);
    for (int t = 0; t < 6; t++) begin
      found = 1'b0;
      for (int c = 0; c < 20; c++) begin
        #1;
        if (arr_start) begin found = 1'b1; break; end
        @(negedge clk);
      end
      chk($sformatf("t%0d_start_seen", t), 32'(found), 32'd1);
      chk($sformatf("t%0d_m", t), 32'(tile_m), 32'(t / 3));
      chk($sformatf("t%0d_n", t), 32'(tile_n), 32'd0);
      chk($sformatf("t%0d_k", t), 32'(tile_k), 32'(t % 3));
      chk($sformatf("t%0d_clear", t), 32'(arr_clear), 32'((t % 3) == 0));
      chk($sformatf("t%0d_store", t), 32'(arr_store), 32'((t % 3) == 2));
      finish_tile();
    end
    @(negedge clk); #1;
    chk("mnk_jdone", 32'(job_done), 32'd1);
    chk("mnk_no_extra_start", 32'(arr_start), 32'd0);

    // Zero k count: straight to DONE
    @(negedge clk);
    job_valid = 1'b1; job_m_tiles = 4'd1; job_n_tiles = 4'd1; job_k_tiles = 4'd0;
    @(negedge clk); job_valid = 1'b0; #1;
    chk("zero_jdone", 32'(job_done), 32'd1);
    chk("zero_start", 32'(arr_start), 32'd0);
    @(negedge clk); #1;
    chk("zero_ready", 32'(job_ready), 32'd1);

    // Abort in ISSUE: no start, aborted pulse, back to IDLE
    issue_job(4'd1, 4'd1, 4'd1);
    abort = 1'b1; #1;
    chk("abi_start", 32'(arr_start), 32'd0);
    chk("abi_jabort", 32'(job_aborted), 32'd1);
    @(negedge clk); abort = 1'b0; #1;
    chk("abi_ready", 32'(job_ready), 32'd1);

    // Abort in WAIT, arr_done three cycles later
    issue_job(4'd1, 4'd1, 4'd2);
    #1 chk("abw_start", 32'(arr_start), 32'd1);
    @(negedge clk); abort = 1'b1; #1;
    chk("abw_pend_only", 32'(job_aborted), 32'd0);
    @(negedge clk); abort = 1'b0;
    @(negedge clk);
    @(negedge clk); arr_done = 1'b1; #1;
    chk("abw_jabort", 32'(job_aborted), 32'd1);
    chk("abw_jdone", 32'(job_done), 32'd0);
    @(negedge clk); arr_done = 1'b0; #1;
    chk("abw_ready", 32'(job_ready), 32'd1);
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      if (arr_start || job_done || job_aborted) cnt++;
    end
    chk("abw_quiet", 32'(cnt), 32'd0);

    // Spurious arr_done in ISSUE is ignored
    issue_job(4'd1, 4'd1, 4'd1);
    arr_done = 1'b1; #1;
    chk("sp_start", 32'(arr_start), 32'd1);
    @(negedge clk); arr_done = 1'b0;
    @(negedge clk); #1;
    chk("sp_no_done", 32'(job_done), 32'd0);
    chk("sp_busy", 32'(busy), 32'd1);
    arr_done = 1'b1;
    @(negedge clk); arr_done = 1'b0;
    @(negedge clk); #1;
    chk("sp_jdone", 32'(job_done), 32'd1);

    // Reset during WAIT of the third tile, then a fresh 1x1x1 job
    issue_job(4'd1, 4'd1, 4'd3);
    finish_tile();
    @(negedge clk);
    finish_tile();
    @(negedge clk);
    @(negedge clk); #1;
    chk("mr_k_before", 32'(tile_k), 32'd2);
    rst = 1'b1; #1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_flags", {29'd0, arr_start, arr_clear, arr_store}, 32'd0);
    chk("mr_idx", {20'd0, tile_m, tile_n, tile_k}, 32'd0);
    chk("mr_bcyc", busy_cycles, 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("mr_ready", 32'(job_ready), 32'd1);
    chk("mr_pulses", {30'd0, job_done, job_aborted}, 32'd0);
    issue_job(4'd1, 4'd1, 4'd1);
    finish_tile();
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (job_done) begin found = 1'b1; break; end
    end
    chk("mr_new_jdone", 32'(found), 32'd1);
    chk("mr_new_bcyc", busy_cycles, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
